// File: rtl/pattern_pkg.sv
// Shared definitions for pattern_gen: mode encodings and the 10-colour palette
// in RGB565 and channel-replicated RGB888 form.
package pattern_pkg;

    typedef enum logic [1:0] {
        MODE_VBAR   = 2'd0,
        MODE_HBAR   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_t;

    localparam int         PAL_SIZE  = 10;
    localparam logic [3:0] IDX_BLACK = 4'd7;
    localparam logic [3:0] IDX_WHITE = 4'd8;

    function automatic logic [15:0] pal_rgb565(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'hF800;  // RED
            4'd1:    return 16'hFC00;  // ORANGE
            4'd2:    return 16'hFFE0;  // YELLOW
            4'd3:    return 16'h07E0;  // GREEN
            4'd4:    return 16'h07FF;  // CYAN
            4'd5:    return 16'h001F;  // BLUE
            4'd6:    return 16'hF81F;  // PURPLE
            4'd7:    return 16'h0000;  // BLACK
            4'd8:    return 16'hFFFF;  // WHITE
            4'd9:    return 16'hD69A;  // GRAY
            default: return 16'h0000;
        endcase
    endfunction

    // 5/6-bit channels widened by repeating their top bits into the low bits
    function automatic logic [23:0] pal_rgb888(input logic [3:0] idx);
        case (idx)
            4'd0:    return 24'hFF0000;
            4'd1:    return 24'hFF8200;
            4'd2:    return 24'hFFFF00;
            4'd3:    return 24'h00FF00;
            4'd4:    return 24'h00FFFF;
            4'd5:    return 24'h0000FF;
            4'd6:    return 24'hFF00FF;
            4'd7:    return 24'h000000;
            4'd8:    return 24'hFFFFFF;
            4'd9:    return 24'hD6D3D6;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] palette_color(input logic [3:0] idx, input int pix_w);
        if (pix_w == 24)
            return pal_rgb888(idx);
        else
            return {8'h00, pal_rgb565(idx)};
    endfunction

endpackage

// File: rtl/bar_index_calc.sv
// Maps a coordinate to a bar index 0..NUM_BARS-1 with a constant comparison
// chain; the last bar absorbs any remainder of LEN/NUM_BARS.
module bar_index_calc #(
    parameter int LEN      = 640,
    parameter int NUM_BARS = 10,
    parameter int COORD_W  = 10
) (
    input  logic [COORD_W-1:0] coord,
    output logic [3:0]         bar_idx
);

    localparam int BAR_LEN = LEN / NUM_BARS;

    generate
        if (NUM_BARS < 1 || NUM_BARS > 10) begin : g_bad_num_bars
            $error("bar_index_calc: NUM_BARS must be 1..10");
        end
    endgenerate

    logic [NUM_BARS-1:0] at_or_past;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BARS; gi++) begin : g_thresh
            if (gi == 0) begin : g_first
                assign at_or_past[gi] = 1'b1;
            end else begin : g_rest
                localparam logic [COORD_W:0] THRESH = (COORD_W+1)'(gi * BAR_LEN);
                assign at_or_past[gi] = ({1'b0, coord} >= THRESH);
            end
        end
    endgenerate

    // Thresholds are monotonic, so the highest one passed is the bar index
    always_comb begin
        bar_idx = 4'd0;
        for (int i = 0; i < NUM_BARS; i++) begin
            if (at_or_past[i])
                bar_idx = 4'(i);
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern source (vbars, hbars, checker, scrolling vbars), registered output.
// Optional white frame border enabled by defining PATGEN_BORDER_EN.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int H_VALID    = 640,
    parameter int V_VALID    = 480,
    parameter int COORD_W    = 10,
    parameter int PIX_W      = 16,
    parameter int NUM_BARS   = 10,
    parameter int CHECK_LOG2 = 5
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [1:0]         mode_sel,
    input  logic [3:0]         scroll_step,
    output logic [PIX_W-1:0]   pix_data,
    output logic               frame_end
);

    generate
        if (PIX_W != 16 && PIX_W != 24) begin : g_bad_pix_w
            $error("pattern_gen: PIX_W must be 16 or 24");
        end
        if (CHECK_LOG2 >= COORD_W) begin : g_bad_check
            $error("pattern_gen: CHECK_LOG2 must be below COORD_W");
        end
    endgenerate

    localparam logic [COORD_W:0]   H_VALID_W = (COORD_W+1)'(H_VALID);
    localparam logic [COORD_W:0]   V_VALID_W = (COORD_W+1)'(V_VALID);
    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_VALID - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_VALID - 1);

    mode_t              mode_reg,      mode_next;
    logic [COORD_W-1:0] offset_reg,    offset_next;
    logic [PIX_W-1:0]   pix_data_reg,  pix_data_next;
    logic               frame_end_reg, frame_end_next;

    logic [COORD_W:0]   ex_sum;
    logic [COORD_W-1:0] ex;
    logic [COORD_W:0]   offset_sum;
    logic [COORD_W-1:0] offset_wrapped;
    logic [COORD_W-1:0] x_coord;
    logic [3:0]         x_idx;
    logic [3:0]         y_idx;
    logic [3:0]         color_idx;
    logic               active;
    logic               frame_last;
    logic               checker_cell;

    // Scrolled column wraps back into the active width with one subtraction
    assign ex_sum = {1'b0, pix_x} + {1'b0, offset_reg};
    assign ex     = (ex_sum >= H_VALID_W) ? COORD_W'(ex_sum - H_VALID_W)
                                          : ex_sum[COORD_W-1:0];

    assign offset_sum     = {1'b0, offset_reg} + (COORD_W+1)'(scroll_step);
    assign offset_wrapped = (offset_sum >= H_VALID_W) ? COORD_W'(offset_sum - H_VALID_W)
                                                      : offset_sum[COORD_W-1:0];

    assign x_coord      = (mode_reg == MODE_SCROLL) ? ex : pix_x;
    assign active       = ({1'b0, pix_x} < H_VALID_W) && ({1'b0, pix_y} < V_VALID_W);
    assign frame_last   = (pix_x == H_LAST) && (pix_y == V_LAST);
    assign checker_cell = pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2];

    bar_index_calc #(
        .LEN      (H_VALID),
        .NUM_BARS (NUM_BARS),
        .COORD_W  (COORD_W)
    ) u_x_idx (
        .coord   (x_coord),
        .bar_idx (x_idx)
    );

    bar_index_calc #(
        .LEN      (V_VALID),
        .NUM_BARS (NUM_BARS),
        .COORD_W  (COORD_W)
    ) u_y_idx (
        .coord   (pix_y),
        .bar_idx (y_idx)
    );

    always_comb begin
        mode_next      = mode_reg;
        offset_next    = offset_reg;
        frame_end_next = frame_last;
        // Mode and scroll only change at the frame boundary so a frame is never mixed
        if (frame_last) begin
            mode_next   = mode_t'(mode_sel);
            offset_next = offset_wrapped;
        end

        case (mode_reg)
            MODE_VBAR:   color_idx = x_idx;
            MODE_HBAR:   color_idx = y_idx;
            MODE_CHECK:  color_idx = checker_cell ? IDX_BLACK : IDX_WHITE;
            MODE_SCROLL: color_idx = x_idx;
            default:     color_idx = x_idx;
        endcase
`ifdef PATGEN_BORDER_EN
        if (pix_x == '0 || pix_x == H_LAST || pix_y == '0 || pix_y == V_LAST)
            color_idx = IDX_WHITE;
`endif
        if (!active)
            color_idx = IDX_BLACK;

        pix_data_next = PIX_W'(palette_color(color_idx, PIX_W));
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_reg      <= MODE_VBAR;
            offset_reg    <= '0;
            pix_data_reg  <= '0;
            frame_end_reg <= 1'b0;
        end else begin
            mode_reg      <= mode_next;
            offset_reg    <= offset_next;
            pix_data_reg  <= pix_data_next;
            frame_end_reg <= frame_end_next;
        end
    end

    assign pix_data  = pix_data_reg;
    assign frame_end = frame_end_reg;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen at default parameters (640x480, RGB565, 10 bars).
module tb_pattern_gen;

`ifdef PATGEN_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    logic        vga_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [1:0]  mode_sel = 2'd0;
    logic [3:0]  scroll_step = 4'd0;
    logic [15:0] pix_data;
    logic        frame_end;

    int checks = 0;
    int errors = 0;
    int pulses;

    pattern_gen #(
        .H_VALID    (640),
        .V_VALID    (480),
        .COORD_W    (10),
        .PIX_W      (16),
        .NUM_BARS   (10),
        .CHECK_LOG2 (5)
    ) dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .mode_sel    (mode_sel),
        .scroll_step (scroll_step),
        .pix_data    (pix_data),
        .frame_end   (frame_end)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %s: observed %h expected %h", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Border pixels turn white when the optional border is built in
    function automatic logic [23:0] bdr(input int x, input int y, input logic [23:0] v);
        if (BORDER_EN && x < 640 && y < 480 && (x == 0 || x == 639 || y == 0 || y == 479))
            return 24'h00FFFF;
        return v;
    endfunction

    task automatic step(input int x, input int y);
        @(negedge vga_clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(posedge vga_clk);
        #1;
    endtask

    task automatic px(input int x, input int y, input logic [23:0] exp, input string tag);
        step(x, y);
        chk(tag, {8'h00, pix_data}, bdr(x, y, exp));
    endtask

    initial begin
        #1 sys_rst_n = 1'b0;
        pix_x = 10'd100;
        pix_y = 10'd10;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_pix", {8'h00, pix_data}, 24'h0000);
        chk("rst_fe", {23'h0, frame_end}, 24'h0);

        // Release and present the first coordinate on the same falling edge
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        pix_x = 10'd63;
        pix_y = 10'd10;
        #1 chk("lat_pre", {8'h00, pix_data}, 24'h0000);
        @(posedge vga_clk);
        #1 chk("m0_x63", {8'h00, pix_data}, 24'hF800);

        px(64, 10, 24'hFC00, "m0_x64");
        px(320, 10, 24'h001F, "m0_x320");
        px(639, 10, 24'hD69A, "m0_x639");
        px(700, 10, 24'h0000, "m0_x700");
        px(10, 480, 24'h0000, "m0_y480");

        mode_sel = 2'd1;
        px(639, 479, 24'hD69A, "fe1_pix");
        chk("fe1_pulse", {23'h0, frame_end}, 24'h1);
        px(5, 47, 24'hF800, "m1_y47");
        chk("fe1_clear", {23'h0, frame_end}, 24'h0);
        px(5, 48, 24'hFC00, "m1_y48");
        px(5, 100, 24'hFFE0, "m1_y100");
        px(5, 479, 24'hD69A, "m1_y479");

        mode_sel = 2'd2;
        px(639, 479, 24'hD69A, "fe2_pix");
        px(0, 0, 24'hFFFF, "m2_0_0");
        px(32, 0, 24'h0000, "m2_32_0");
        px(32, 32, 24'hFFFF, "m2_32_32");
        px(31, 33, 24'h0000, "m2_31_33");
        px(0, 100, 24'h0000, "m2_0_100");
        px(1, 100, 24'h0000, "m2_1_100");

        mode_sel = 2'd0;
        px(639, 479, 24'h0000, "fe3_pix");
        px(0, 100, 24'hF800, "sw_bar0");
        mode_sel = 2'd2;
        px(100, 100, 24'hFC00, "sw_hold_a");
        px(320, 200, 24'h001F, "sw_hold_b");
        px(639, 479, 24'hD69A, "fe4_pix");
        px(0, 0, 24'hFFFF, "sw_chk_a");
        px(32, 0, 24'h0000, "sw_chk_b");

        mode_sel = 2'd3;
        scroll_step = 4'd0;
        px(639, 479, 24'h0000, "fe5_pix");
        px(60, 10, 24'hF800, "m3_off0");
        scroll_step = 4'd4;
        px(639, 479, 24'hD69A, "fe6_pix");
        chk("fe6_pulse", {23'h0, frame_end}, 24'h1);
        px(0, 0, 24'hF800, "m3_x0");
        chk("fe6_clear", {23'h0, frame_end}, 24'h0);
        px(60, 10, 24'hFC00, "m3_x60");
        px(636, 10, 24'hF800, "m3_x636_wrap");
        px(635, 10, 24'hD69A, "m3_x635");

        // 158 more frames at step 4 take the offset from 4 to 636
        pulses = 0;
        for (int f = 0; f < 158; f++) begin
            step(639, 479);
            pulses += int'(frame_end);
            step(0, 0);
            pulses += int'(frame_end);
        end
        chk("preload_pulses", 24'(pulses), 24'd158);
        px(3, 10, 24'hD69A, "o636_x3");
        px(4, 10, 24'hF800, "o636_x4");
        px(100, 10, 24'hFC00, "o636_x100");

        scroll_step = 4'd8;
        step(639, 479);
        px(60, 10, 24'hFC00, "wrap8_x60");
        px(59, 10, 24'hF800, "wrap8_x59");

        // 49 frames at step 4 take the offset from 4 to 200
        scroll_step = 4'd4;
        for (int f = 0; f < 49; f++) begin
            step(639, 479);
            step(0, 0);
        end
        px(439, 10, 24'hD69A, "o200_x439");
        px(440, 10, 24'hF800, "o200_x440");
        px(100, 50, 24'h07FF, "o200_x100");

        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_pix", {8'h00, pix_data}, 24'h0000);
        chk("arst_fe", {23'h0, frame_end}, 24'h0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        px(100, 50, 24'hFC00, "post_rst_m0");
        scroll_step = 4'd0;
        px(639, 479, 24'hD69A, "fe7_pix");
        px(60, 10, 24'hF800, "post_rst_x60");
        px(64, 10, 24'hFC00, "post_rst_x64");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
